// File: rtl/half_match_arbiter.sv
// Round-robin arbiter in front of a single half-word match evaluator.
// One request is accepted in IDLE, evaluated in EVAL, and its tagged result
// is presented in RESP.
//
// Handshakes: a request transfers in the IDLE cycle where req_rd[i] is high.
// req_rd is a combinational function of req_vld and rr_ptr, and it is never
// raised outside IDLE. A response transfers on the rising edge where
// resp_vld & resp_rd are both 1. resp_data and resp_id hold steady while
// resp_vld=1 and resp_rd=0.
module half_match_arbiter #(
  parameter int REQ_CNT    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MATCH_VAL  = 1,
  parameter int CNT_WIDTH  = 16,
  localparam int ID_W      = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REQ_CNT*DATA_WIDTH-1:0] req_data,
  input  logic [REQ_CNT-1:0]            req_vld,
  output logic [REQ_CNT-1:0]            req_rd,
  output logic                          resp_data,
  output logic [ID_W-1:0]               resp_id,
  output logic                          resp_vld,
  input  logic                          resp_rd,
  output logic [CNT_WIDTH-1:0]          match_cnt
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [HALF-1:0] MATCH_H = HALF'(MATCH_VAL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ID_W-1:0]       rr_ptr;
  logic [DATA_WIDTH-1:0] op_q;
  logic [ID_W-1:0]       id_q;

  logic                  grant_vld;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       grant_nxt_ptr;
  int                    scan_idx;

  logic                  lo_eq;
  logic                  hi_eq;
  logic [1:0]            eq_sum;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 0; k < REQ_CNT; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= REQ_CNT) scan_idx = scan_idx - REQ_CNT;
      if (!grant_vld && req_vld[scan_idx[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[ID_W-1:0];
      end
    end
    grant_nxt_ptr = (grant_idx == ID_W'(REQ_CNT - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Evaluator: the +1 on {hi_eq, lo_eq} wraps to 0 only when both halves match.
  always_comb begin
    lo_eq  = (op_q[HALF-1:0] == MATCH_H);
    hi_eq  = (op_q[DATA_WIDTH-1:HALF] == MATCH_H);
    eq_sum = {hi_eq, lo_eq} + 2'b01;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and grant strobe; req_rd is forced low while reset is asserted.
  always_comb begin
    state_nxt = state;
    req_rd    = '0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_rd[grant_idx] = 1'b1;
          state_nxt         = EVAL;
        end
      end
      EVAL:    state_nxt = RESP;
      RESP:    if (resp_rd) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) req_rd = '0;
  end

  // Datapath: operand capture, pointer advance, result and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      op_q      <= '0;
      id_q      <= '0;
      resp_vld  <= 1'b0;
      resp_data <= 1'b0;
      resp_id   <= '0;
      match_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_q   <= req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            id_q   <= grant_idx;
            rr_ptr <= grant_nxt_ptr;
          end
        end
        EVAL: begin
          resp_data <= (eq_sum != 2'b00);
          resp_id   <= id_q;
          resp_vld  <= 1'b1;
          if ((eq_sum == 2'b00) && (match_cnt != {CNT_WIDTH{1'b1}}))
            match_cnt <= match_cnt + 1'b1;
        end
        RESP: begin
          if (resp_rd) resp_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
